// File: rtl/chunk_sched_pkg.sv
// Shared sizing constants and read-FSM states for the
// chunk scheduler and its slot trackers.
package chunk_sched_pkg;

  localparam int MEM_SIZE         = 128;
  localparam int BUS_SIZE         = 32;
  localparam int PREFIX_SUM_SIZE  = 8;
  localparam int CHUNK_CNT_W      = 8;

  localparam int WR_DAT_CYC_NUM   = MEM_SIZE / BUS_SIZE;
  localparam int RD_SPARSEMAP_NUM = MEM_SIZE / PREFIX_SUM_SIZE;

  localparam int WR_CNT_W = $clog2(WR_DAT_CYC_NUM);
  localparam int SM_W     = $clog2(RD_SPARSEMAP_NUM);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    START,
    RUN
  } sched_state_e;

endpackage

// File: rtl/chunk_slot_tracker.sv
// Ping-pong slot occupancy for one operand: steers write
// beats into the free slot and frees the slot being read.
module chunk_slot_tracker
  import chunk_sched_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  input  logic                release_i,
  input  logic                rsel_i,
  output logic                in_ready_o,
  output logic                wr_valid_o,
  output logic [WR_CNT_W-1:0] wr_count_o,
  output logic                wr_sel_o,
  output logic [1:0]          full_o
);

  logic                wsel_q, wsel_d;
  logic [WR_CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]          full_q, full_d;
  logic                acc;

  // Accept beats into the write slot; mark it full on the
  // last beat and move on to the other slot.
  always_comb begin
    acc        = in_valid_i && !full_q[wsel_q];
    in_ready_o = !full_q[wsel_q];
    wr_valid_o = acc;
    wr_count_o = cnt_q;
    wr_sel_o   = wsel_q;
    full_o     = full_q;
    full_d     = full_q;
    wsel_d     = wsel_q;
    cnt_d      = cnt_q;
    if (release_i) full_d[rsel_i] = 1'b0;
    if (acc) begin
      cnt_d = cnt_q + WR_CNT_W'(1);
      if (cnt_q == WR_CNT_W'(WR_DAT_CYC_NUM - 1)) begin
        full_d[wsel_q] = 1'b1;
        wsel_d         = !wsel_q;
        cnt_d          = '0;
      end
    end
  end

  // Occupancy state registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wsel_q <= 1'b0;
      cnt_q  <= '0;
      full_q <= '0;
    end else begin
      wsel_q <= wsel_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/chunk_scheduler.sv
// Control sequencer for one input selector and its IFM and
// filter ping-pong chunk buffers; carries no data.
module chunk_scheduler
  import chunk_sched_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cfg_valid_i,
  output logic                   cfg_ready_o,
  input  logic [CHUNK_CNT_W-1:0] cfg_chunk_num_i,
  input  logic [SM_W-1:0]        cfg_sparsemap_num_i,
  input  logic                   ifm_in_valid_i,
  output logic                   ifm_in_ready_o,
  input  logic                   filter_in_valid_i,
  output logic                   filter_in_ready_o,
  output logic                   ifm_wr_valid_o,
  output logic                   filter_wr_valid_o,
  output logic [WR_CNT_W-1:0]    ifm_wr_count_o,
  output logic [WR_CNT_W-1:0]    filter_wr_count_o,
  output logic                   ifm_wr_sel_o,
  output logic                   filter_wr_sel_o,
  output logic                   ifm_rd_sel_o,
  output logic                   filter_rd_sel_o,
  output logic                   chunk_start_o,
  output logic                   run_valid_o,
  output logic [SM_W-1:0]        rd_sparsemap_num_o,
  input  logic                   chunk_end_i,
  output logic                   out_done_o,
  output logic                   busy_o
);

  sched_state_e           state_q, state_d;
  logic                   rsel_q, rsel_d;
  logic [CHUNK_CNT_W-1:0] cnt_q, cnt_d;
  logic [CHUNK_CNT_W-1:0] num_q, num_d;
  logic [SM_W-1:0]        sm_q, sm_d;
  logic [1:0]             ifm_full, flt_full;
  logic                   finish, last;

  chunk_slot_tracker u_ifm (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (ifm_in_valid_i),
    .release_i  (finish),
    .rsel_i     (rsel_q),
    .in_ready_o (ifm_in_ready_o),
    .wr_valid_o (ifm_wr_valid_o),
    .wr_count_o (ifm_wr_count_o),
    .wr_sel_o   (ifm_wr_sel_o),
    .full_o     (ifm_full)
  );

  chunk_slot_tracker u_flt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .in_valid_i (filter_in_valid_i),
    .release_i  (finish),
    .rsel_i     (rsel_q),
    .in_ready_o (filter_in_ready_o),
    .wr_valid_o (filter_wr_valid_o),
    .wr_count_o (filter_wr_count_o),
    .wr_sel_o   (filter_wr_sel_o),
    .full_o     (flt_full)
  );

  // Outputs decoded from registered state; chunk_end only
  // counts while a chunk is actually running.
  always_comb begin
    cfg_ready_o        = (state_q == IDLE);
    busy_o             = (state_q != IDLE);
    chunk_start_o      = (state_q == START);
    run_valid_o        = (state_q == START) || (state_q == RUN);
    ifm_rd_sel_o       = rsel_q;
    filter_rd_sel_o    = rsel_q;
    rd_sparsemap_num_o = sm_q;
    finish             = run_valid_o && chunk_end_i;
    last               = (cnt_q == num_q - CHUNK_CNT_W'(1));
    out_done_o         = finish && last;
  end

  // Read sequencing: wait for both operands, launch, run
  // until the selector ends the chunk, then release.
  always_comb begin
    state_d = state_q;
    rsel_d  = rsel_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    sm_d    = sm_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_valid_i) begin
          num_d   = (cfg_chunk_num_i == '0) ?
                    CHUNK_CNT_W'(1) : cfg_chunk_num_i;
          sm_d    = cfg_sparsemap_num_i;
          cnt_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (ifm_full[rsel_q] && flt_full[rsel_q])
          state_d = START;
      end
      START, RUN: begin
        state_d = RUN;
        if (finish) begin
          rsel_d = !rsel_q;
          if (last) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + CHUNK_CNT_W'(1);
            state_d = WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and job configuration registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rsel_q  <= 1'b0;
      cnt_q   <= '0;
      num_q   <= '0;
      sm_q    <= '0;
    end else begin
      state_q <= state_d;
      rsel_q  <= rsel_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      sm_q    <= sm_d;
    end
  end

endmodule

// File: tb/tb_chunk_scheduler.sv
// Randomized bench for chunk_scheduler against a
// slot-count reference model.
module tb_chunk_scheduler;
  import chunk_sched_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cfg_valid;
  logic                   cfg_ready;
  logic [CHUNK_CNT_W-1:0] cfg_num;
  logic [SM_W-1:0]        cfg_sm;
  logic                   ifm_v, ifm_r, flt_v, flt_r;
  logic                   ifm_wv, flt_wv;
  logic [WR_CNT_W-1:0]    ifm_wc, flt_wc;
  logic                   ifm_ws, flt_ws, ifm_rs, flt_rs;
  logic                   cstart, runv, cend, done, busy;
  logic [SM_W-1:0]        rd_sm;

  always #5 clk = ~clk;

  chunk_scheduler dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .cfg_valid_i         (cfg_valid),
    .cfg_ready_o         (cfg_ready),
    .cfg_chunk_num_i     (cfg_num),
    .cfg_sparsemap_num_i (cfg_sm),
    .ifm_in_valid_i      (ifm_v),
    .ifm_in_ready_o      (ifm_r),
    .filter_in_valid_i   (flt_v),
    .filter_in_ready_o   (flt_r),
    .ifm_wr_valid_o      (ifm_wv),
    .filter_wr_valid_o   (flt_wv),
    .ifm_wr_count_o      (ifm_wc),
    .filter_wr_count_o   (flt_wc),
    .ifm_wr_sel_o        (ifm_ws),
    .filter_wr_sel_o     (flt_ws),
    .ifm_rd_sel_o        (ifm_rs),
    .filter_rd_sel_o     (flt_rs),
    .chunk_start_o       (cstart),
    .run_valid_o         (runv),
    .rd_sparsemap_num_o  (rd_sm),
    .chunk_end_i         (cend),
    .out_done_o          (done),
    .busy_o              (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag,
                          input logic [31:0] obs,
                          input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h @%0t",
               tag, obs, exp, $time);
    end
  endtask

  // Reference model: per operand, how many whole chunks
  // sit buffered, the beat index and the slot being filled;
  // read side tracks job progress as chunks left.
  int m_full [2];
  int m_beat [2];
  int m_wslot[2];
  bit m_busy;
  int m_phase;
  int m_left;
  int m_rslot;
  int m_sm;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_full[k]  = 0;
      m_beat[k]  = 0;
      m_wslot[k] = 0;
    end
    m_busy  = 1'b0;
    m_phase = 0;
    m_left  = 0;
    m_rslot = 0;
    m_sm    = 0;
  endtask

  task automatic step(input bit r, input bit iv,
                      input bit fv, input bit cv,
                      input int num, input int sm,
                      input bit ce);
    bit v[2], rdy[2], acc[2];
    bit st, run, fin, dn;
    @(negedge clk);
    rst       = r;
    ifm_v     = iv;
    flt_v     = fv;
    cfg_valid = cv;
    cfg_num   = CHUNK_CNT_W'(num);
    cfg_sm    = SM_W'(sm);
    cend      = ce;
    #1;
    v[0] = iv;
    v[1] = fv;
    for (int k = 0; k < 2; k++) begin
      rdy[k] = (m_full[k] < 2);
      acc[k] = v[k] && rdy[k];
    end
    st  = m_busy && (m_phase == 1);
    run = m_busy && (m_phase >= 1);
    fin = run && ce;
    dn  = fin && (m_left == 1);
    check_eq("cfg_ready", cfg_ready, !m_busy);
    check_eq("busy", busy, m_busy);
    check_eq("ifm_ready", ifm_r, rdy[0]);
    check_eq("flt_ready", flt_r, rdy[1]);
    check_eq("ifm_wr_valid", ifm_wv, acc[0]);
    check_eq("flt_wr_valid", flt_wv, acc[1]);
    check_eq("ifm_wr_count", ifm_wc, m_beat[0]);
    check_eq("flt_wr_count", flt_wc, m_beat[1]);
    check_eq("ifm_wr_sel", ifm_ws, m_wslot[0]);
    check_eq("flt_wr_sel", flt_ws, m_wslot[1]);
    check_eq("ifm_rd_sel", ifm_rs, m_rslot);
    check_eq("flt_rd_sel", flt_rs, m_rslot);
    check_eq("chunk_start", cstart, st);
    check_eq("run_valid", runv, run);
    check_eq("out_done", done, dn);
    check_eq("rd_sparsemap", rd_sm, m_sm);
    if (r) begin
      model_reset();
      return;
    end
    if (!m_busy) begin
      if (cv) begin
        m_busy  = 1'b1;
        m_phase = 0;
        m_left  = (num == 0) ? 1 : num;
        m_sm    = sm;
      end
    end else if (m_phase == 0) begin
      if (m_full[0] >= 1 && m_full[1] >= 1) m_phase = 1;
    end else if (fin) begin
      m_rslot ^= 1;
      m_left--;
      if (m_left == 0) m_busy = 1'b0;
      else m_phase = 0;
    end else begin
      m_phase = 2;
    end
    for (int k = 0; k < 2; k++) begin
      if (acc[k]) begin
        if (m_beat[k] == WR_DAT_CYC_NUM - 1) begin
          m_beat[k]   = 0;
          m_full[k]++;
          m_wslot[k] ^= 1;
        end else begin
          m_beat[k]++;
        end
      end
      if (fin) m_full[k]--;
    end
  endtask

  function automatic bit pick(input int pct);
    return $urandom_range(99, 0) < pct;
  endfunction

  initial begin
    int p_i, p_f, p_e, p_c, p_r, nmax;
    rst       = 1'b1;
    ifm_v     = 1'b0;
    flt_v     = 1'b0;
    cfg_valid = 1'b0;
    cfg_num   = '0;
    cfg_sm    = '0;
    cend      = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Directed opener: two-chunk job, IFM then filter.
    step(0, 0, 0, 1, 2, 3, 0);
    repeat (4) step(0, 1, 0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 1, 0, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    // Selector holds end high while the job waits.
    repeat (10) step(0, 0, 0, 0, 0, 0, 1);
    repeat (8) step(0, 1, 1, 0, 0, 0, 1);
    repeat (4) step(0, 0, 0, 0, 0, 0, 0);
    for (int seg = 0; seg < 16; seg++) begin
      p_i  = $urandom_range(100, 0);
      p_f  = (seg % 5 == 2) ? 0 : $urandom_range(100, 0);
      p_e  = $urandom_range(95, 5);
      p_c  = $urandom_range(60, 5);
      p_r  = (seg % 4 == 3) ? 2 : 0;
      nmax = (seg % 3 == 0) ? 255 : 3;
      for (int c = 0; c < 200; c++)
        step(pick(p_r), pick(p_i), pick(p_f), pick(p_c),
             $urandom_range(nmax, 0),
             $urandom_range(RD_SPARSEMAP_NUM - 1, 0),
             pick(p_e));
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
